// File: rtl/thread_lsu_if.sv
// Data-memory handshake bundle between a thread LSU (master) and the memory controller (slave).
interface thread_lsu_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: issues one data-memory read or write per REQUEST stage
// and reports completion through lsu_state so the scheduler can release WAIT.
module thread_lsu #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [7:0]           rs,
  input  logic [7:0]           rt,
  thread_lsu_if.master         mem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic [7:0]           wait_cycles
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    REQUESTING = 2'b01,
    WAITING    = 2'b10,
    DONE       = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    STAGE_REQUEST = 3'b011,
    STAGE_UPDATE  = 3'b110
  } stage_t;

  state_t state;
  logic   is_read;

  assign lsu_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      is_read               <= 1'b0;
      mem.mem_read_valid    <= 1'b0;
      mem.mem_read_address  <= '0;
      mem.mem_write_valid   <= 1'b0;
      mem.mem_write_address <= '0;
      mem.mem_write_data    <= '0;
      lsu_out               <= '0;
      wait_cycles           <= '0;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          // Read wins when both decode bits are set; the write is dropped.
          if (core_state == STAGE_REQUEST &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            is_read <= decoded_mem_read_enable;
            state   <= REQUESTING;
          end
        end
        REQUESTING: begin
          wait_cycles <= '0;
          if (is_read) begin
            mem.mem_read_address <= rs[ADDR_BITS-1:0];
            mem.mem_read_valid   <= 1'b1;
          end else begin
            mem.mem_write_address <= rs[ADDR_BITS-1:0];
            mem.mem_write_data    <= rt[DATA_BITS-1:0];
            mem.mem_write_valid   <= 1'b1;
          end
          state <= WAITING;
        end
        WAITING: begin
          if (is_read && mem.mem_read_valid && mem.mem_read_ready) begin
            lsu_out            <= mem.mem_read_data;
            mem.mem_read_valid <= 1'b0;
            state              <= DONE;
          end else if (!is_read && mem.mem_write_valid && mem.mem_write_ready) begin
            mem.mem_write_valid <= 1'b0;
            state               <= DONE;
          end else if (wait_cycles != '1) begin
            wait_cycles <= wait_cycles + 8'd1;
          end
        end
        DONE: begin
          if (core_state == STAGE_UPDATE)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thread_lsu.sv
// Directed bench for thread_lsu: a per-cycle vector table plus hand sequences for long waits and reset.
module tb_thread_lsu;

  localparam logic [2:0] CS_OTH = 3'b000;
  localparam logic [2:0] CS_REQ = 3'b011;
  localparam logic [2:0] CS_WT  = 3'b100;
  localparam logic [2:0] CS_UPD = 3'b110;

  logic       clk = 1'b0;
  logic       reset, enable, rd_en, wr_en;
  logic [2:0] core_state;
  logic [7:0] rs, rt;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out, wait_cycles;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  thread_lsu_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem_if ();

  thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem                      (mem_if),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out),
    .wait_cycles              (wait_cycles)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {state, rv, raddr, wv, waddr, wdata, lsu_out, wait_cycles}.
  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] cs;
    logic       rd;
    logic       wr;
    logic [7:0] rs_v;
    logic [7:0] rt_v;
    logic       rrdy;
    logic [7:0] rdat;
    logic       wrdy;
    logic [43:0] exp;
  } vec_t;

  function automatic logic [43:0] ex(logic [1:0] st, logic rv, logic [7:0] ra, logic wv,
                                     logic [7:0] wa, logic [7:0] wd, logic [7:0] o, logic [7:0] wc);
    return {st, rv, ra, wv, wa, wd, o, wc};
  endfunction

  function automatic vec_t mk(logic rst, logic en, logic [2:0] cs, logic rd, logic wr,
                              logic [7:0] rs_v, logic [7:0] rt_v, logic rrdy, logic [7:0] rdat,
                              logic wrdy, logic [43:0] exp);
    return '{rst, en, cs, rd, wr, rs_v, rt_v, rrdy, rdat, wrdy, exp};
  endfunction

  function automatic logic [43:0] observed();
    return {lsu_state, mem_if.mem_read_valid, mem_if.mem_read_address, mem_if.mem_write_valid,
            mem_if.mem_write_address, mem_if.mem_write_data, lsu_out, wait_cycles};
  endfunction

  task automatic check(input string nm, input logic [43:0] act, input logic [43:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; enable = v.en; core_state = v.cs; rd_en = v.rd; wr_en = v.wr;
    rs = v.rs_v; rt = v.rt_v;
    mem_if.mem_read_ready = v.rrdy; mem_if.mem_read_data = v.rdat;
    mem_if.mem_write_ready = v.wrdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // Idle, then idle-channel readies with valid low.
    vecs.push_back(mk(1,1,CS_OTH,0,0,8'h00,8'h00,0,8'h00,0, ex(0,0,8'h00,0,8'h00,8'h00,8'h00,8'd0)));
    vecs.push_back(mk(0,1,CS_OTH,0,0,8'h00,8'h00,1,8'hAA,0, ex(0,0,8'h00,0,8'h00,8'h00,8'h00,8'd0)));
    vecs.push_back(mk(0,1,CS_WT ,0,0,8'h00,8'h00,1,8'hAA,1, ex(0,0,8'h00,0,8'h00,8'h00,8'h00,8'd0)));
    // Load 0x2A, ready after two waiting cycles, data 0x5C.
    vecs.push_back(mk(0,1,CS_REQ,1,0,8'h2A,8'h00,0,8'h00,0, ex(1,0,8'h00,0,8'h00,8'h00,8'h00,8'd0)));
    vecs.push_back(mk(0,1,CS_WT ,1,0,8'h2A,8'h00,0,8'h00,0, ex(2,1,8'h2A,0,8'h00,8'h00,8'h00,8'd0)));
    vecs.push_back(mk(0,1,CS_WT ,1,0,8'h2A,8'h00,0,8'h00,0, ex(2,1,8'h2A,0,8'h00,8'h00,8'h00,8'd1)));
    vecs.push_back(mk(0,1,CS_WT ,1,0,8'h2A,8'h00,0,8'h00,0, ex(2,1,8'h2A,0,8'h00,8'h00,8'h00,8'd2)));
    vecs.push_back(mk(0,1,CS_WT ,1,0,8'h2A,8'h00,1,8'h5C,0, ex(3,0,8'h2A,0,8'h00,8'h00,8'h5C,8'd2)));
    vecs.push_back(mk(0,1,CS_WT ,0,0,8'h2A,8'h00,0,8'h00,0, ex(3,0,8'h2A,0,8'h00,8'h00,8'h5C,8'd2)));
    vecs.push_back(mk(0,1,CS_UPD,0,0,8'h2A,8'h00,0,8'h00,0, ex(0,0,8'h2A,0,8'h00,8'h00,8'h5C,8'd2)));
    // Store 0x10 <- 0xF3, ready already high on the first valid cycle.
    vecs.push_back(mk(0,1,CS_REQ,0,1,8'h10,8'hF3,0,8'h00,0, ex(1,0,8'h2A,0,8'h00,8'h00,8'h5C,8'd2)));
    vecs.push_back(mk(0,1,CS_WT ,0,1,8'h10,8'hF3,0,8'h00,1, ex(2,0,8'h2A,1,8'h10,8'hF3,8'h5C,8'd0)));
    vecs.push_back(mk(0,1,CS_WT ,0,1,8'h10,8'hF3,0,8'h00,1, ex(3,0,8'h2A,0,8'h10,8'hF3,8'h5C,8'd0)));
    vecs.push_back(mk(0,1,CS_UPD,0,0,8'h10,8'hF3,0,8'h00,0, ex(0,0,8'h2A,0,8'h10,8'hF3,8'h5C,8'd0)));
    // Both enables: read wins, write-channel ready ignored.
    vecs.push_back(mk(0,1,CS_REQ,1,1,8'h04,8'h77,0,8'h00,0, ex(1,0,8'h2A,0,8'h10,8'hF3,8'h5C,8'd0)));
    vecs.push_back(mk(0,1,CS_WT ,1,1,8'h04,8'h77,0,8'h00,0, ex(2,1,8'h04,0,8'h10,8'hF3,8'h5C,8'd0)));
    vecs.push_back(mk(0,1,CS_WT ,1,1,8'h04,8'h77,0,8'h00,1, ex(2,1,8'h04,0,8'h10,8'hF3,8'h5C,8'd1)));
    vecs.push_back(mk(0,1,CS_WT ,1,1,8'h04,8'h77,1,8'h3C,0, ex(3,0,8'h04,0,8'h10,8'hF3,8'h3C,8'd1)));
    vecs.push_back(mk(0,1,CS_UPD,0,0,8'h04,8'h77,0,8'h00,0, ex(0,0,8'h04,0,8'h10,8'hF3,8'h3C,8'd1)));
    // Disabled thread in REQUEST stays idle; non-memory instruction stays idle.
    vecs.push_back(mk(0,0,CS_REQ,1,0,8'h55,8'h00,0,8'h00,0, ex(0,0,8'h04,0,8'h10,8'hF3,8'h3C,8'd1)));
    vecs.push_back(mk(0,1,CS_WT ,1,0,8'h55,8'h00,0,8'h00,0, ex(0,0,8'h04,0,8'h10,8'hF3,8'h3C,8'd1)));
    vecs.push_back(mk(0,1,CS_REQ,0,0,8'h55,8'h00,0,8'h00,0, ex(0,0,8'h04,0,8'h10,8'hF3,8'h3C,8'd1)));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      check($sformatf("vec%0d", i), observed(), vecs[i].exp);
    end

    // Long wait: valid/address hold while wait_cycles saturates at 255.
    drive(mk(0,1,CS_REQ,1,0,8'h99,8'h00,0,8'h00,0,'0));
    tick();
    drive(mk(0,1,CS_WT ,1,0,8'h99,8'h00,0,8'h00,0,'0));
    tick();
    check("long_start", observed(), ex(2,1,8'h99,0,8'h10,8'hF3,8'h3C,8'd0));
    for (int k = 1; k <= 300; k++) begin
      tick();
      check($sformatf("long_wait%0d", k), observed(),
            ex(2,1,8'h99,0,8'h10,8'hF3,8'h3C,(k > 255) ? 8'd255 : 8'(k)));
    end
    drive(mk(0,1,CS_WT ,1,0,8'h99,8'h00,1,8'hE1,0,'0));
    tick();
    check("long_done", observed(), ex(3,0,8'h99,0,8'h10,8'hF3,8'hE1,8'd255));
    drive(mk(0,1,CS_UPD,0,0,8'h99,8'h00,0,8'h00,0,'0));
    tick();
    check("long_update", observed(), ex(0,0,8'h99,0,8'h10,8'hF3,8'hE1,8'd255));

    // Reset while WAITING, then a clean load to 0x01.
    drive(mk(0,1,CS_REQ,1,0,8'h20,8'h00,0,8'h00,0,'0));
    tick();
    drive(mk(0,1,CS_WT ,1,0,8'h20,8'h00,0,8'h00,0,'0));
    tick();
    check("rst_pre", observed(), ex(2,1,8'h20,0,8'h10,8'hF3,8'hE1,8'd0));
    drive(mk(1,1,CS_WT ,1,0,8'h20,8'h00,1,8'h66,0,'0));
    tick();
    check("rst_mid", observed(), ex(0,0,8'h00,0,8'h00,8'h00,8'h00,8'd0));
    drive(mk(0,1,CS_REQ,1,0,8'h01,8'h00,0,8'h00,0,'0));
    tick();
    check("post_req", observed(), ex(1,0,8'h00,0,8'h00,8'h00,8'h00,8'd0));
    drive(mk(0,1,CS_WT ,1,0,8'h01,8'h00,0,8'h00,0,'0));
    tick();
    check("post_wait", observed(), ex(2,1,8'h01,0,8'h00,8'h00,8'h00,8'd0));
    drive(mk(0,1,CS_WT ,1,0,8'h01,8'h00,1,8'h42,0,'0));
    tick();
    check("post_done", observed(), ex(3,0,8'h01,0,8'h00,8'h00,8'h42,8'd0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/thread_lsu.md
Name: thread_lsu

Overview:
- Per-thread load/store unit.
- Consumes the rs/rt operand values driven by the thread register file and issues a single data-memory read or write through a valid/ready handshake.
- Returns load data on lsu_out, which the register file writes back in the UPDATE stage.
- Exposes its state so the core scheduler can hold the WAIT stage until every active thread's memory access has completed.

Parameters:
- ADDR_BITS, 8, data-memory address width; must be ≤ 8. Address is rs[ADDR_BITS-1:0].
- DATA_BITS, 8, data word width; equals the register width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  thread active in current block; when low the unit stays in IDLE
- core_state  input  3  core pipeline stage: 011=REQUEST, 100=WAIT, 110=UPDATE; other codes are don't-care
- decoded_mem_read_enable  input  1  current instruction is LDR
- decoded_mem_write_enable  input  1  current instruction is STR
- rs  input  8  address operand from the register file
- rt  input  8  store-data operand from the register file
- mem_read_valid  output  1  read request
- mem_read_address  output  ADDR_BITS  read address
- mem_read_ready  input  1  read completion; mem_read_data is valid in the same cycle
- mem_read_data  input  DATA_BITS  read data
- mem_write_valid  output  1  write request
- mem_write_address  output  ADDR_BITS  write address
- mem_write_data  output  DATA_BITS  write data
- mem_write_ready  input  1  write accepted
- lsu_state  output  2  00=IDLE, 01=REQUESTING, 10=WAITING, 11=DONE
- lsu_out  output  DATA_BITS  last loaded value
- wait_cycles  output  8  WAITING-cycle count of the most recent transaction

Behaviour:
- All logic updates on posedge clk.
- Reset: state IDLE, and every output is 0 (valids, addresses, write data, lsu_out, wait_cycles). Reset mid-transaction drops valid at that edge; no completion is reported.
- enable low: no state change, all outputs hold.
- Operation type is latched in IDLE. Read has priority if both enables are set; the write is then ignored.
- IDLE: core_state==REQUEST and (read or write enable) → REQUESTING. Otherwise stay IDLE.
- REQUESTING (exactly 1 cycle, lets rs/rt settle):
  - Load: drive mem_read_address<=rs[ADDR_BITS-1:0] and mem_read_valid<=1.
  - Store: drive mem_write_address<=rs[ADDR_BITS-1:0], mem_write_data<=rt[DATA_BITS-1:0] and mem_write_valid<=1.
  - In both cases clear wait_cycles to 0 and go → WAITING.
- WAITING: valid, address and data are held stable until the matching ready is sampled high.
  - Each cycle without ready: wait_cycles increments, saturating at 255.
  - Load, mem_read_ready=1: lsu_out<=mem_read_data, mem_read_valid<=0, → DONE.
  - Store, mem_write_ready=1: mem_write_valid<=0, → DONE. lsu_out is unchanged.
  - The cycle in which ready is sampled is not counted.
- Ready asserted while the corresponding valid is low is ignored. The non-active channel's ready is always ignored.
- DONE: core_state==UPDATE → IDLE; otherwise stay DONE. lsu_out holds until the next load completes.
- Minimum latency from the REQUEST edge to DONE is 3 edges (ready high the first cycle valid is high).
- Non-memory instruction in REQUEST: stays IDLE and lsu_state stays 00, so the scheduler does not stall on this thread.

Test Plan:
- Reset, then idle: all outputs 0 and lsu_state=00. Assert mem_read_ready=1 with valid low → no change.
- Load: rs=0x2A, read_en, REQUEST for one cycle. Memory returns 0x5C with ready 2 cycles after valid rises → read_address=0x2A, valid held 3 cycles, lsu_out=0x5C, wait_cycles=2, lsu_state=11; UPDATE → 00.
- Store: rs=0x10, rt=0xF3, write_en. Ready is high on the first valid cycle → write_address=0x10, write_data=0xF3, single-cycle valid, wait_cycles=0, lsu_out unchanged.
- Both enables set with rs=0x04 → only mem_read_valid rises and write_valid stays 0. Separately, enable=0 during REQUEST → remains IDLE.
- Ready withheld for 300 cycles → valid/address stable throughout, wait_cycles saturates at 255; ready then → DONE.
- Reset asserted in WAITING → valid 0 next edge, state 00, lsu_out 0. A subsequent load to 0x01 completes normally.
